// File: rtl/square_reconstruct_if.sv
// Handshake and operand/result bundle for square_reconstruct.
// The master drives start/root/residue; the slave returns the reconstructed radicand.
interface square_reconstruct_if #(
  parameter int WORD_LENGTH = 16
);
  localparam int N = WORD_LENGTH / 2;

  logic                   start;
  logic [N-1:0]           root;
  logic [WORD_LENGTH-1:0] residue;
  logic                   busy;
  logic                   done;
  logic [WORD_LENGTH-1:0] radicand;
  logic                   overflow;
  logic                   residue_err;

  modport master (
    output start, root, residue,
    input  busy, done, radicand, overflow, residue_err
  );

  modport slave (
    input  start, root, residue,
    output busy, done, radicand, overflow, residue_err
  );
endinterface

// File: rtl/square_reconstruct.sv
// Iterative squarer: radicand = root*root + residue, one root bit per clock (MSB first).
// Optional residue legality check (residue > 2*root) under SQUARE_RECONSTRUCT_RESIDUE_CHECK_EN.
module square_reconstruct #(
  parameter int WORD_LENGTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  square_reconstruct_if.slave bus
);
  localparam int N  = WORD_LENGTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WORD_LENGTH:0]   acc_q, acc_d;
  logic [N-1:0]           q_reg_q, q_reg_d;
  logic [WORD_LENGTH-1:0] r_reg_q, r_reg_d;
  logic [WORD_LENGTH-1:0] radicand_q, radicand_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic                   residue_err_q, residue_err_d;

  logic [WORD_LENGTH:0]   sum;
  logic [WORD_LENGTH:0]   addend;
  logic                   res_bad;

  assign addend = q_reg_q[cnt_q] ? {{(WORD_LENGTH+1-N){1'b0}}, q_reg_q} : '0;
  assign sum    = acc_q + {1'b0, r_reg_q};

`ifdef SQUARE_RECONSTRUCT_RESIDUE_CHECK_EN
  assign res_bad = {1'b0, r_reg_q} > {{(WORD_LENGTH-N){1'b0}}, q_reg_q, 1'b0};
`else
  assign res_bad = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    q_reg_d       = q_reg_q;
    r_reg_d       = r_reg_q;
    radicand_d    = radicand_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    overflow_d    = overflow_q;
    residue_err_d = residue_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          q_reg_d = bus.root;
          r_reg_d = bus.residue;
          acc_d   = '0;
          cnt_d   = CW'(N - 1);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Horner form of q*q: shift in one partial product per root bit.
        acc_d = (acc_q << 1) + addend;
        if (cnt_q == '0) state_d = ST_ADD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ADD: begin
        radicand_d    = sum[WORD_LENGTH-1:0];
        overflow_d    = sum[WORD_LENGTH];
        residue_err_d = res_bad;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      q_reg_q       <= '0;
      r_reg_q       <= '0;
      radicand_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      residue_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      q_reg_q       <= q_reg_d;
      r_reg_q       <= r_reg_d;
      radicand_q    <= radicand_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      residue_err_q <= residue_err_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.radicand    = radicand_q;
  assign bus.overflow    = overflow_q;
  assign bus.residue_err = residue_err_q;
endmodule

// File: tb/tb_square_reconstruct.sv
// Directed bench for square_reconstruct: a scoreboard of expected results pushed at
// start and checked by a done-monitor, plus reset/abort and hold checks.
module tb_square_reconstruct;
  localparam int WL = 16;
  localparam int N  = WL / 2;
  localparam int LAT = N + 1;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;

  typedef struct {
    logic [WL-1:0] rad;
    logic          ov;
    logic          err;
    int            sc;
  } exp_t;

  exp_t sb[$];

  square_reconstruct_if #(.WORD_LENGTH(WL)) bus ();

  square_reconstruct #(.WORD_LENGTH(WL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic drive_start(input logic [N-1:0] r, input logic [WL-1:0] res);
    exp_t e;
    logic [WL:0] full;
    full = {1'b0, res} + (17'(r) * 17'(r));
    e.rad = full[WL-1:0];
    e.ov  = full[WL];
`ifdef SQUARE_RECONSTRUCT_RESIDUE_CHECK_EN
    e.err = ({1'b0, res} > (17'(r) << 1));
`else
    e.err = 1'b0;
`endif
    e.sc  = cyc + 1;
    sb.push_back(e);
    bus.start   = 1'b1;
    bus.root    = r;
    bus.residue = res;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  // Done monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.done === 1'b1) begin
        check("unexpected_done", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("radicand", 32'(bus.radicand), 32'(e.rad));
          check("overflow", 32'(bus.overflow), 32'(e.ov));
          check("residue_err", 32'(bus.residue_err), 32'(e.err));
          check("latency", 32'(cyc - e.sc), 32'(LAT));
          check("busy_at_done", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.start   = 1'b0;
    bus.root    = '0;
    bus.residue = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_radicand", 32'(bus.radicand), 32'h0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_residue_err", 32'(bus.residue_err), 32'd0);

    // 0xB5^2 + 6 = 0x7FFF
    drive_start(8'hB5, 16'h0006);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_radicand", 32'(bus.radicand), 32'h7FFF);
    check("hold_done_low", 32'(bus.done), 32'd0);

    // Largest non-overflowing sum, then one past it (also an illegal residue).
    drive_start(8'hFF, 16'h01FE);
    wait_done();
    @(negedge clk);
    drive_start(8'hFF, 16'h01FF);
    wait_done();
    @(negedge clk);

    // Back-to-back: second start lands in the first done cycle.
    drive_start(8'h00, 16'h0000);
    wait_done();
    drive_start(8'h10, 16'h0003);
    wait_done();
    @(negedge clk);

    // Abort: busy-ignored start, then reset mid-operation.
    drive_start(8'h80, 16'h0000);
    @(negedge clk);
    bus.start = 1'b1;
    bus.root  = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignored_start_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_radicand", 32'(bus.radicand), 32'h0);
    check("abort_overflow", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2 * LAT) @(negedge clk);
    check("abort_idle_busy", 32'(bus.busy), 32'd0);

    drive_start(8'h03, 16'h0000);
    wait_done();
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
